// File: rtl/task_map_pkg.sv
// Shared types and constants for the task-graph streamer and its matrix store.
package task_map_pkg;

  localparam int DATA_W   = 32;
  localparam int SLOT_CYC = 2;
  localparam int END_CYC  = 2;
  localparam int GAP_CYC  = 1;

  typedef enum logic [2:0] {
    IDLE,
    SLOT0,
    SLOT1,
    END0,
    END1,
    GAP
  } state_e;

  typedef logic [DATA_W-1:0] edge_t;

endpackage

// File: rtl/task_graph_streamer_if.sv
// Stream bus from the task-graph streamer to the task mapper.
interface task_graph_streamer_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 1
);
  logic [DATA_W-1:0] task_array;
  logic [IDX_W-1:0]  row;
  logic [IDX_W-1:0]  col;
  logic              root_task;
  logic              app_end;
  logic [2:0]        nz_count;

  modport master (output task_array, row, col, root_task, app_end, nz_count);
  modport slave  (input  task_array, row, col, root_task, app_end, nz_count);
endinterface

// File: rtl/task_graph_mem.sv
// NUM_V x NUM_V edge-weight register file: one synchronous write port, combinational reads.
// The transposed read port exists only when TASK_STREAM_SYM_CHECK_EN is defined.
module task_graph_mem #(
  parameter int NUM_V  = 2,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [IDX_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_row,
  input  logic [IDX_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data
`ifdef TASK_STREAM_SYM_CHECK_EN
  ,
  output logic [DATA_W-1:0] rd_data_t
`endif
);
  localparam int DEPTH = NUM_V * NUM_V;
  localparam int AW    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  function automatic logic [AW-1:0] addr(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return AW'(int'(r) * NUM_V + int'(c));
  endfunction

  always_ff @(posedge clk) begin
    if (rst_b) begin
      mem_q <= '{default: '0};
    end else if (we && (int'(wr_row) < NUM_V) && (int'(wr_col) < NUM_V)) begin
      mem_q[addr(wr_row, wr_col)] <= wr_data;
    end
  end

  assign rd_data = mem_q[addr(rd_row, rd_col)];
`ifdef TASK_STREAM_SYM_CHECK_EN
  assign rd_data_t = mem_q[addr(rd_col, rd_row)];
`endif

endmodule

// File: rtl/task_graph_streamer.sv
// Streams a stored NUM_V x NUM_V task graph row-major to the task mapper, rep_cnt times per start.
// Define TASK_STREAM_SYM_CHECK_EN to add the sticky sym_err symmetry check.
//
// state | meaning
// IDLE  | waiting for start; matrix writes accepted
// SLOT0 | first cycle of an element slot
// SLOT1 | second cycle of an element slot
// END0  | first app_end cycle
// END1  | second app_end cycle
// GAP   | repeat the application or pulse done
module task_graph_streamer #(
  parameter int NUM_V  = 2,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(NUM_V)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_row,
  input  logic [IDX_W-1:0]      wr_col,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_drop,
  input  logic                  start,
  input  logic [15:0]           rep_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  sym_err,
  task_graph_streamer_if.master strm
);
  import task_map_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_V - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
  logic [DATA_W-1:0] task_q, task_d, rd_data, elem;
  logic              root_q, root_d, app_end_q, app_end_d, done_q, done_d, drop_q;
  logic [2:0]        nz_q, nz_d, nz_base;
  logic [15:0]       rem_q, rem_d;
  logic              we, enter;
`ifdef TASK_STREAM_SYM_CHECK_EN
  logic [DATA_W-1:0] rd_data_t, elem_t;
  logic              sym_q;
`endif

  assign we = wr_en && (state_q == IDLE);

  task_graph_mem #(.NUM_V(NUM_V), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_mem (
    .clk, .rst_b, .we, .wr_row, .wr_col, .wr_data,
    .rd_row (row_d),
    .rd_col (col_d),
    .rd_data
`ifdef TASK_STREAM_SYM_CHECK_EN
    , .rd_data_t
`endif
  );

  // A write landing with start must be seen by the (0,0) slot loaded on the same edge.
  assign elem = (we && wr_row == row_d && wr_col == col_d) ? wr_data : rd_data;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rem_d     = rem_q;
    app_end_d = 1'b0;
    done_d    = 1'b0;
    enter     = 1'b0;
    nz_base   = nz_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SLOT0;
        row_d   = '0;
        col_d   = '0;
        rem_d   = (rep_cnt == 16'd0) ? 16'd1 : rep_cnt;
        nz_base = '0;
        enter   = 1'b1;
      end
      SLOT0: state_d = SLOT1;
      SLOT1: if (row_q == LAST && col_q == LAST) begin
        state_d   = END0;
        app_end_d = 1'b1;
      end else begin
        state_d = SLOT0;
        enter   = 1'b1;
        if (col_q == LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      END0: begin
        state_d   = END1;
        app_end_d = 1'b1;
      end
      END1: begin
        state_d = GAP;
        done_d  = (rem_q <= 16'd1);
      end
      GAP: if (rem_q > 16'd1) begin
        rem_d   = rem_q - 16'd1;
        state_d = SLOT0;
        row_d   = '0;
        col_d   = '0;
        nz_base = '0;
        enter   = 1'b1;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    task_d = task_q;
    root_d = root_q;
    nz_d   = nz_q;
    if (enter) begin
      task_d = elem;
      root_d = (elem != '0) && (nz_base == 3'd0);
      nz_d   = ((elem != '0) && (nz_base != 3'd7)) ? nz_base + 3'd1 : nz_base;
    end else if (state_d == END0) begin
      task_d = '0;
      root_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q   <= IDLE;
      row_q     <= LAST;
      col_q     <= LAST;
      task_q    <= '0;
      root_q    <= 1'b0;
      app_end_q <= 1'b0;
      nz_q      <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      task_q    <= task_d;
      root_q    <= root_d;
      app_end_q <= app_end_d;
      nz_q      <= nz_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      drop_q    <= wr_en && (state_q != IDLE);
    end
  end

`ifdef TASK_STREAM_SYM_CHECK_EN
  assign elem_t = (we && wr_row == col_d && wr_col == row_d) ? wr_data : rd_data_t;

  // Sticky per run: an accepted start discards the previous run's flag.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      sym_q <= 1'b0;
    end else if (enter) begin
      sym_q <= ((state_q == IDLE) ? 1'b0 : sym_q) | (elem != elem_t);
    end
  end
  assign sym_err = sym_q;
`else
  assign sym_err = 1'b0;
`endif

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign wr_drop = drop_q;

  assign strm.task_array = task_q;
  assign strm.row        = row_q;
  assign strm.col        = col_q;
  assign strm.root_task  = root_q;
  assign strm.app_end    = app_end_q;
  assign strm.nz_count   = nz_q;

endmodule

// File: tb/tb_task_graph_streamer.sv
// Bench for task_graph_streamer: NUM_V=2 and NUM_V=4 instances checked every cycle against a
// trace model built from the stored matrices, plus directed literal checks.
module tb_task_graph_streamer;

  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] ta;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        root;
    logic        ae;
    logic [2:0]  nz;
    logic        done;
    logic        busy;
    logic        sym;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_b = 1'b1;
  logic [1:0]    wr_row = '0, wr_col = '0;
  logic [DW-1:0] wr_data = '0;
  logic [15:0]   rep_cnt = '0;
  logic          wr_en2 = 1'b0, wr_en4 = 1'b0, start2 = 1'b0, start4 = 1'b0;
  logic          wr_drop2, wr_drop4, busy2, busy4, done2, done4, sym2, sym4;

  task_graph_streamer_if #(.DATA_W(DW), .IDX_W(1)) s2 ();
  task_graph_streamer_if #(.DATA_W(DW), .IDX_W(2)) s4 ();

  task_graph_streamer #(.NUM_V(2), .DATA_W(DW)) dut2 (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en2), .wr_row(wr_row[0:0]), .wr_col(wr_col[0:0]),
    .wr_data(wr_data), .wr_drop(wr_drop2), .start(start2), .rep_cnt(rep_cnt),
    .busy(busy2), .done(done2), .sym_err(sym2), .strm(s2)
  );

  task_graph_streamer #(.NUM_V(4), .DATA_W(DW)) dut4 (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en4), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .wr_drop(wr_drop4), .start(start4), .rep_cnt(rep_cnt),
    .busy(busy4), .done(done4), .sym_err(sym4), .strm(s4)
  );

  int          n_tests = 0, n_fail = 0, cur = 0;
  logic        chk_en = 1'b0;
  logic [31:0] mat [2][16];
  exp_t        q2[$], q4[$], bq[$];
  exp_t        idle2, idle4;

  function automatic exp_t reset_idle(input int n);
    exp_t e;
    e = '{ta: 32'd0, r: 2'(n-1), c: 2'(n-1), root: 1'b0, ae: 1'b0, nz: 3'd0,
          done: 1'b0, busy: 1'b0, sym: 1'b0};
    return e;
  endfunction

  // Expected per-cycle trace of one start: the start-presented idle cycle, then every stream cycle.
  task automatic build(input int w, input int reps);
    int n, na, nz;
    logic rooted, root, sym;
    logic [31:0] v;
    exp_t e;
    n = (w == 0) ? 2 : 4;
    na = (reps == 0) ? 1 : reps;
    sym = 1'b0;
    bq.delete();
    bq.push_back((w == 0) ? idle2 : idle4);
    for (int a = 0; a < na; a++) begin
      nz = 0;
      rooted = 1'b0;
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          v = mat[w][r*n+c];
          root = (v != 0) && !rooted;
          if (root) rooted = 1'b1;
          if (v != 0 && nz < 7) nz++;
`ifdef TASK_STREAM_SYM_CHECK_EN
          if (v != mat[w][c*n+r]) sym = 1'b1;
`endif
          e = '{ta: v, r: 2'(r), c: 2'(c), root: root, ae: 1'b0, nz: 3'(nz),
                done: 1'b0, busy: 1'b1, sym: sym};
          bq.push_back(e);
          bq.push_back(e);
        end
      end
      e = '{ta: 32'd0, r: 2'(n-1), c: 2'(n-1), root: 1'b0, ae: 1'b1, nz: 3'(nz),
            done: 1'b0, busy: 1'b1, sym: sym};
      bq.push_back(e);
      bq.push_back(e);
      e.ae = 1'b0;
      e.done = (a == na - 1);
      bq.push_back(e);
    end
    e.done = 1'b0;
    e.busy = 1'b0;
    if (w == 0) begin q2 = bq; idle2 = e; end
    else begin q4 = bq; idle4 = e; end
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    if (chk_en) begin
      if (q2.size() > 0) e = q2.pop_front(); else e = idle2;
      g = '{ta: s2.task_array, r: {1'b0, s2.row}, c: {1'b0, s2.col}, root: s2.root_task,
            ae: s2.app_end, nz: s2.nz_count, done: done2, busy: busy2, sym: sym2};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL stream2 @%0t: got %h expected %h", $time, g, e);
      end
      if (q4.size() > 0) e = q4.pop_front(); else e = idle4;
      g = '{ta: s4.task_array, r: s4.row, c: s4.col, root: s4.root_task,
            ae: s4.app_end, nz: s4.nz_count, done: done4, busy: busy4, sym: sym4};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL stream4 @%0t: got %h expected %h", $time, g, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic to_cyc(input int k);
    while (cur < k) tick();
  endtask

  task automatic wr(input int w, input int r, input int c, input logic [31:0] d);
    logic drop_exp;
    int n;
    n = (w == 0) ? 2 : 4;
    drop_exp = (w == 0) ? (q2.size() > 0) : (q4.size() > 0);
    wr_row = 2'(r);
    wr_col = 2'(c);
    wr_data = d;
    if (w == 0) wr_en2 = 1'b1; else wr_en4 = 1'b1;
    if (!drop_exp) mat[w][r*n+c] = d;
    tick();
    wr_en2 = 1'b0;
    wr_en4 = 1'b0;
    chk("wr_drop", (w == 0) ? wr_drop2 : wr_drop4, {31'b0, drop_exp});
  endtask

  // Start edge is cycle 0; returns inside cycle 1.
  task automatic go(input int w, input int reps);
    rep_cnt = 16'(reps);
    if (w == 0) start2 = 1'b1; else start4 = 1'b1;
    if (((w == 0) ? q2.size() : q4.size()) == 0) build(w, reps);
    cur = 0;
    tick();
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  initial begin
    int cnt, dcyc;
    for (int w = 0; w < 2; w++) for (int i = 0; i < 16; i++) mat[w][i] = 32'd0;
    idle2 = reset_idle(2);
    idle4 = reset_idle(4);

    // reset state
    tick(); tick();
    chk_en = 1'b1;
    tick();
    chk("rst_task", s2.task_array, 0);
    chk("rst_row2", s2.row, 1);
    chk("rst_col4", s4.col, 3);
    chk("rst_busy", busy2, 0);
    chk("rst_wr_drop", wr_drop2, 0);
    rst_b = 1'b0;
    tick();

    // test 1: {{0,5},{5,0}}, one application
    wr(0, 0, 0, 0); wr(0, 0, 1, 5); wr(0, 1, 0, 5); wr(0, 1, 1, 0);
    go(0, 1);
    chk("t1_c1_task", s2.task_array, 0);
    to_cyc(3);
    chk("t1_c3_task", s2.task_array, 5);
    chk("t1_c3_root", s2.root_task, 1);
    to_cyc(4);
    start2 = 1'b1;
    to_cyc(5);
    start2 = 1'b0;
    chk("t1_c5_root", s2.root_task, 0);
    to_cyc(9);
    chk("t1_app_end", s2.app_end, 1);
    chk("t1_nz", s2.nz_count, 2);
    to_cyc(11);
    chk("t1_done", done2, 1);
    to_cyc(12);
    chk("t1_busy_off", busy2, 0);

    // test 2: all-zero matrix, rep_cnt 0 behaves as 1
    wr(0, 0, 1, 0); wr(0, 1, 0, 0);
    go(0, 0);
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      to_cyc(k);
      if (s2.root_task) cnt++;
      if (k == 10) chk("t2_nz", s2.nz_count, 0);
      if (k == 11) chk("t2_done", done2, 1);
    end
    chk("t2_root_slots", cnt, 0);

    // test 3: three applications
    wr(0, 0, 1, 5); wr(0, 1, 0, 5);
    go(0, 3);
    cnt = 0;
    dcyc = 0;
    for (int k = 1; k <= 35; k++) begin
      to_cyc(k);
      if (done2) begin cnt++; dcyc = k; end
      if (k == 3 || k == 14 || k == 25) chk("t3_root", s2.root_task, 1);
    end
    chk("t3_done_count", cnt, 1);
    chk("t3_done_cycle", dcyc, 33);

    // test 4: NUM_V=4 all ones; (0,0) written together with start
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (r != 0 || c != 0) wr(1, r, c, 1);
    wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'd1; wr_en4 = 1'b1;
    mat[1][0] = 32'd1;
    go(1, 1);
    wr_en4 = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      to_cyc(k);
      if (s4.root_task) cnt++;
      if (k == 1) chk("t4_root00", s4.root_task, 1);
      if (k == 34) chk("t4_nz_sat", s4.nz_count, 7);
      if (k == 35) chk("t4_done", done4, 1);
    end
    chk("t4_root_slots", cnt, 2);
    chk("t4_busy_off", busy4, 0);

    // test 5: write while busy is dropped, then reset mid-stream
    go(0, 1);
    to_cyc(2);
    wr(0, 0, 0, 9);
    to_cyc(4);
    chk("t5_drop_off", wr_drop2, 0);
    to_cyc(13);
    go(0, 1);
    chk("t5_old_val", s2.task_array, 0);
    to_cyc(5);
    rst_b = 1'b1;
    tick();
    q2.delete();
    q4.delete();
    for (int w = 0; w < 2; w++) for (int i = 0; i < 16; i++) mat[w][i] = 32'd0;
    idle2 = reset_idle(2);
    idle4 = reset_idle(4);
    chk("t5_rst_busy", busy2, 0);
    chk("t5_rst_row", s2.row, 1);
    chk("t5_rst_nz4", s4.nz_count, 0);
    rst_b = 1'b0;
    for (int k = 7; k <= 12; k++) begin
      to_cyc(k);
      chk("t5_no_done", done2, 0);
    end
    go(0, 1);
    to_cyc(3);
    chk("t5_cleared", s2.task_array, 0);
    to_cyc(13);

`ifdef TASK_STREAM_SYM_CHECK_EN
    // test 6: asymmetric matrix sets sym_err until the next start
    wr(0, 0, 1, 5); wr(0, 1, 0, 6);
    go(0, 1);
    to_cyc(2);
    chk("t6_sym_c2", sym2, 0);
    to_cyc(3);
    chk("t6_sym_c3", sym2, 1);
    to_cyc(13);
    chk("t6_sym_hold", sym2, 1);
    go(0, 1);
    chk("t6_sym_clr", sym2, 0);
    to_cyc(13);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
